ptl_rx_deser: RTL and testbench

PTL_RX_DESER -- requirements
Module: ptl_rx_deser

---
 rtl/ptl_rx_deser_if.sv | 30 +++
 rtl/ptl_rx_deser.sv | 154 +++++++++++++++
 tb/tb_ptl_rx_deser.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ptl_rx_deser_if.sv
// ptl_rx_deser_if -- receive-side bundle for the PTL deserializer.
//   din        : PTL receive bit, one sample per clk (1 = SFQ pulse seen)
//   dout       : head-of-buffer data word (zero when dout_valid=0)
//   dout_valid : dout holds a valid word
//   dout_ready : consumer accepts dout this cycle
//   locked     : deserializer is frame-aligned
//   perr_cnt   : saturating parity error count
//   ovf        : sticky word-dropped-on-full flag
// master = deserializer side, slave = line driver / word consumer side.
interface ptl_rx_deser_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             locked;
  logic [7:0]       perr_cnt;
  logic             ovf;

  modport master (
    input  din, dout_ready,
    output dout, dout_valid, locked, perr_cnt, ovf
  );

  modport slave (
    output din, dout_ready,
    input  dout, dout_valid, locked, perr_cnt, ovf
  );
endinterface

// File: rtl/ptl_rx_deser.sv
// ptl_rx_deser -- PTL serial receive deserializer with frame sync hunt,
// LSB-first data capture, even-parity check and a 2-entry output FIFO.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : ptl_rx_deser_if.master (din, dout, dout_valid, dout_ready,
//         locked, perr_cnt, ovf)
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | shifting din into the sync window, waiting for SYNC
// DATA   | capturing WIDTH data bits LSB-first
// PARITY | checking even parity; good word pushed, bad word -> HUNT
module ptl_rx_deser #(
  parameter int         WIDTH = 8,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input logic           clk,
  input logic           rst,
  ptl_rx_deser_if.master bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [7:0]       perr_q;
  logic             ovf_q;
  logic             push;
  logic             perr_inc;

  logic [WIDTH-1:0] buf0_q, buf1_q;
  logic [1:0]       fcnt_q;
  logic             pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      win_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    push     = 1'b0;
    perr_inc = 1'b0;
    case (state_q)
      HUNT: begin
        win_d = {win_q[6:0], bus.din};
        if (win_d == SYNC) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        word_d[cnt_q] = bus.din;
        if (cnt_q == CNT_LAST) begin
          state_d = PARITY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        // even parity: the parity bit equals the XOR of the data bits
        if (bus.din == ^word_q) begin
          push    = 1'b1;
          state_d = DATA;
        end else begin
          perr_inc = 1'b1;
          state_d  = HUNT;
          win_d    = '0;
        end
      end
      default: begin
        state_d = HUNT;
        win_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= '0;
    end else if (perr_inc && (perr_q != 8'hFF)) begin
      perr_q <= perr_q + 8'd1;
    end
  end

  // buf0 is always the head; buf1 only holds data when two words are queued
  assign pop = (fcnt_q != 2'd0) && bus.dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_q <= '0;
      buf1_q <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (fcnt_q == 2'd2) begin
            buf0_q <= buf1_q;
            buf1_q <= word_q;
          end else begin
            buf0_q <= word_q;
          end
        end
        2'b01: begin
          buf0_q <= buf1_q;
          fcnt_q <= fcnt_q - 2'd1;
        end
        2'b10: begin
          if (fcnt_q == 2'd0) begin
            buf0_q <= word_q;
            fcnt_q <= 2'd1;
          end else if (fcnt_q == 2'd1) begin
            buf1_q <= word_q;
            fcnt_q <= 2'd2;
          end else begin
            ovf_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dout_valid = (fcnt_q != 2'd0);
  assign bus.dout       = bus.dout_valid ? buf0_q : '0;
  assign bus.locked     = (state_q == DATA) || (state_q == PARITY);
  assign bus.perr_cnt   = perr_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_ptl_rx_deser.sv
// tb_ptl_rx_deser -- scoreboard bench for ptl_rx_deser (WIDTH=8, SYNC=A5).
// Good frames push their word into exp_q when the parity bit is driven;
// a negedge monitor pops and compares whenever the DUT hands out a word.
module tb_ptl_rx_deser;

  localparam logic [7:0] SYNC_PAT = 8'hA5;

  logic clk;
  logic rst;

  ptl_rx_deser_if #(.WIDTH(8)) bus ();

  ptl_rx_deser #(.WIDTH(8), .SYNC(SYNC_PAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  int         perr_m = 0;
  logic       ovf_m  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One bit per clock: drive after the edge, return 1 time unit after the next edge.
  task automatic send_bit(input logic b);
    bus.din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_sync();
    for (int i = 7; i >= 1; i--) send_bit(SYNC_PAT[i]);
    chk("locked_before_last_sync_bit", bus.locked, 0);
    send_bit(SYNC_PAT[0]);
    chk("locked_after_sync", bus.locked, 1);
  endtask

  task automatic send_frame(input logic [7:0] w, input bit bad, input bit rdy_last);
    logic par;
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    par = (^w) ^ bad;
    if (rdy_last) bus.dout_ready = 1'b1;
    if (!bad) begin
      if (exp_q.size() < 2 || bus.dout_ready) exp_q.push_back(w);
      else ovf_m = 1'b1;
    end else begin
      if (perr_m < 255) perr_m++;
    end
    send_bit(par);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) chk("pop_with_empty_scoreboard", exp_q.size(), 1);
        else chk("pop_data", bus.dout, exp_q.pop_front());
      end else if (!bus.dout_valid) begin
        chk("dout_zero_when_invalid", bus.dout, 0);
      end
    end
  end

  initial begin
    logic [7:0] w01;
    rst = 1'b1;
    bus.din = 1'b0;
    bus.dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_perr_cnt", bus.perr_cnt, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst = 1'b0;

    // sync detect and first word latency
    send_sync();
    send_frame(8'h3C, 0, 0);
    chk("latency_dout_valid", bus.dout_valid, 1);
    chk("latency_dout", bus.dout, 8'h3C);

    // parity error drops lock; following frame without sync is ignored
    bus.dout_ready = 1'b1;
    send_frame(8'h01, 1, 0);
    chk("perr_cnt_after_err", bus.perr_cnt, perr_m);
    chk("locked_after_err", bus.locked, 0);
    chk("no_push_on_err", bus.dout_valid, 0);
    w01 = 8'h01;
    for (int i = 0; i < 8; i++) send_bit(w01[i]);
    send_bit(1'b1);
    chk("ignored_while_hunting_valid", bus.dout_valid, 0);
    chk("ignored_while_hunting_locked", bus.locked, 0);
    chk("ignored_while_hunting_perr", bus.perr_cnt, perr_m);

    // overflow with consumer stalled
    bus.dout_ready = 1'b0;
    send_sync();
    send_frame(8'h11, 0, 0);
    send_frame(8'h22, 0, 0);
    send_frame(8'h33, 0, 0);
    chk("ovf_set", bus.ovf, ovf_m);
    chk("ovf_head", bus.dout, 8'h11);
    chk("ovf_still_locked", bus.locked, 1);
    bus.dout_ready = 1'b1;
    send_frame(8'h00, 1, 0);
    chk("ovf_drained", bus.dout_valid, 0);
    chk("ovf_scoreboard_empty", exp_q.size(), 0);
    chk("ovf_sticky", bus.ovf, 1);
    chk("perr_cnt_two", bus.perr_cnt, perr_m);

    // asynchronous reset mid-DATA with one word buffered
    bus.dout_ready = 1'b0;
    send_sync();
    send_frame(8'h44, 0, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("pre_rst_valid", bus.dout_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_dout_valid", bus.dout_valid, 0);
    chk("async_rst_dout", bus.dout, 0);
    chk("async_rst_locked", bus.locked, 0);
    chk("async_rst_perr_cnt", bus.perr_cnt, 0);
    chk("async_rst_ovf", bus.ovf, 0);
    exp_q.delete();
    perr_m = 0;
    ovf_m  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_sync();
    send_frame(8'h5A, 0, 0);
    chk("post_rst_dout", bus.dout, 8'h5A);
    bus.dout_ready = 1'b1;
    send_frame(8'hFF, 1, 0);
    chk("post_rst_drained", bus.dout_valid, 0);

    // simultaneous push and pop at full
    bus.dout_ready = 1'b0;
    send_sync();
    send_frame(8'h11, 0, 0);
    send_frame(8'h22, 0, 0);
    send_frame(8'h33, 0, 1);
    chk("pushpop_full_no_ovf", bus.ovf, 0);
    chk("pushpop_full_head", bus.dout, 8'h22);
    send_frame(8'h00, 1, 0);
    chk("pushpop_drained", bus.dout_valid, 0);
    chk("pushpop_scoreboard_empty", exp_q.size(), 0);

    // perr_cnt saturation
    for (int k = 0; k < 260; k++) begin
      send_sync();
      send_frame(8'h01, 1, 0);
    end
    chk("perr_cnt_saturated", bus.perr_cnt, perr_m);
    chk("perr_cnt_is_255", bus.perr_cnt, 255);
    chk("final_ovf", bus.ovf, ovf_m);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
